// File: rtl/arccos_search.sv
// arccos_search: binary search over a 64-entry quarter-wave cosine ROM, giving angle 0..180 deg.
// Optional macro ARCCOS_ROUND_EN rounds the index-to-degree scaling instead of truncating it.
module arccos_search (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] cos_val,
    output logic        busy,
    output logic        done,
    output logic [7:0]  angle
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        FINISH
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [5:0]  r;
    logic [2:0]  bit_cnt;
    logic [7:0]  mag;
    logic        neg;

    logic [16:0] abs_in;
    logic [7:0]  mag_in;
    logic [5:0]  cand;
    logic [7:0]  rom_cand;
    logic        take;
    logic [12:0] scaled;
    logic [6:0]  a_val;
    logic [7:0]  angle_fin;

    // Contents of cos_table_64x8.hex: round(255*cos(i*90/64 deg)), non-increasing.
    function automatic logic [7:0] rom_lookup(input logic [5:0] idx);
        logic [7:0] v;
        case (idx)
            6'd0:  v = 8'd255;
            6'd1:  v = 8'd255;
            6'd2:  v = 8'd255;
            6'd3:  v = 8'd254;
            6'd4:  v = 8'd254;
            6'd5:  v = 8'd253;
            6'd6:  v = 8'd252;
            6'd7:  v = 8'd251;
            6'd8:  v = 8'd250;
            6'd9:  v = 8'd249;
            6'd10: v = 8'd247;
            6'd11: v = 8'd246;
            6'd12: v = 8'd244;
            6'd13: v = 8'd242;
            6'd14: v = 8'd240;
            6'd15: v = 8'd238;
            6'd16: v = 8'd236;
            6'd17: v = 8'd233;
            6'd18: v = 8'd231;
            6'd19: v = 8'd228;
            6'd20: v = 8'd225;
            6'd21: v = 8'd222;
            6'd22: v = 8'd219;
            6'd23: v = 8'd215;
            6'd24: v = 8'd212;
            6'd25: v = 8'd208;
            6'd26: v = 8'd205;
            6'd27: v = 8'd201;
            6'd28: v = 8'd197;
            6'd29: v = 8'd193;
            6'd30: v = 8'd189;
            6'd31: v = 8'd185;
            6'd32: v = 8'd180;
            6'd33: v = 8'd176;
            6'd34: v = 8'd171;
            6'd35: v = 8'd167;
            6'd36: v = 8'd162;
            6'd37: v = 8'd157;
            6'd38: v = 8'd152;
            6'd39: v = 8'd147;
            6'd40: v = 8'd142;
            6'd41: v = 8'd136;
            6'd42: v = 8'd131;
            6'd43: v = 8'd126;
            6'd44: v = 8'd120;
            6'd45: v = 8'd115;
            6'd46: v = 8'd109;
            6'd47: v = 8'd103;
            6'd48: v = 8'd98;
            6'd49: v = 8'd92;
            6'd50: v = 8'd86;
            6'd51: v = 8'd80;
            6'd52: v = 8'd74;
            6'd53: v = 8'd68;
            6'd54: v = 8'd62;
            6'd55: v = 8'd56;
            6'd56: v = 8'd50;
            6'd57: v = 8'd44;
            6'd58: v = 8'd37;
            6'd59: v = 8'd31;
            6'd60: v = 8'd25;
            6'd61: v = 8'd19;
            6'd62: v = 8'd13;
            default: v = 8'd6;
        endcase
        return v;
    endfunction

    // 17-bit negate so that -32768 becomes +32768 before clamping.
    always_comb begin
        abs_in = cos_val[15] ? (17'd0 - {1'b1, cos_val}) : {1'b0, cos_val};
        mag_in = (abs_in > 17'd255) ? 8'hFF : 8'(abs_in);
    end

    always_comb begin
        cand     = r | (6'd1 << bit_cnt);
        rom_cand = rom_lookup(cand);
        take     = (rom_cand >= mag);
    end

    always_comb begin
`ifdef ARCCOS_ROUND_EN
        scaled = {7'd0, r} * 13'd90 + 13'd32;
`else
        scaled = {7'd0, r} * 13'd90;
`endif
        a_val     = 7'(scaled >> 6);
        angle_fin = neg ? (8'd180 - {1'b0, a_val}) : {1'b0, a_val};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SEARCH;
            SEARCH:  if (bit_cnt == 3'd0) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            angle   <= '0;
            r       <= '0;
            bit_cnt <= 3'd5;
            mag     <= '0;
            neg     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag     <= mag_in;
                        neg     <= cos_val[15];
                        r       <= '0;
                        bit_cnt <= 3'd5;
                        busy    <= 1'b1;
                    end
                end
                SEARCH: begin
                    if (take) r <= cand;
                    if (bit_cnt != 3'd0) bit_cnt <= bit_cnt - 3'd1;
                end
                FINISH: begin
                    angle <= angle_fin;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/arccos_search.md
ARCCOS_SEARCH -- requirements
Module: arccos_search

Interface
REQ-001 SHALL have a single clock, clk; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 start  input  1  request pulse; cos_val is captured when start=1, clk rises and the block is idle.
REQ-005 cos_val  input  16  signed two's-complement cosine; 255 = +1.0, -255 = -1.0.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse marking a valid angle.
REQ-008 angle  output  8  unsigned result in degrees, 0..180, held until the next done.

Function
REQ-009 SHALL hold a 64x8 cosine magnitude ROM loaded from cos_table_64x8.hex, with rom[i] = round(255*cos(i*90/64 deg)); rom[0]=255, rom[63]=6.
REQ-010 SHALL form mag = |cos_val|, then clamp it to 255; -32768 also yields 255.
REQ-011 SHALL register the input sign as neg = cos_val[15] at capture.
REQ-012 SHALL implement the state machine IDLE -> SEARCH -> FINISH -> IDLE.
REQ-013 IDLE: on start=1, SHALL capture mag and neg, clear r to 0, set bit counter to 5, assert busy, and go to SEARCH.
REQ-014 SEARCH: once per cycle for bit b = 5 down to 0, SHALL set cand = r | (1<<b) and set r = cand if rom[cand] >= mag; after b=0 SHALL go to FINISH.
REQ-015 At the end of SEARCH, r SHALL be the largest index with rom[r] >= mag; this is valid because the ROM is monotonic non-increasing and rom[0]=255.
REQ-016 FINISH: SHALL compute a = (r*90) >> 6 using a 13-bit intermediate; angle SHALL be a if neg=0, else 180 - a.
REQ-017 FINISH: SHALL register angle, set done=1, set busy=0, and go to IDLE.
REQ-018 Latency: start sampled at edge N SHALL give angle and done valid after edge N+7; done SHALL clear after edge N+8.
REQ-019 start while busy=1 SHALL be ignored, with no effect on the current conversion.
REQ-020 start in the cycle done=1 SHALL be accepted, allowing back-to-back conversions every 8 cycles.
REQ-021 cos_val SHALL be don't-care except at the capture edge.
REQ-022 angle SHALL NOT change except at the FINISH edge or on reset.

Reset
REQ-023 When rst_n=0 at a clk edge, SHALL set state=IDLE, busy=0, done=0, angle=0, r=0, and bit counter=5.
REQ-024 Reset mid-SEARCH or mid-FINISH SHALL abort the conversion with no done pulse; the first start after rst_n returns high SHALL be accepted normally.

Configuration
REQ-025 Macro ARCCOS_ROUND_EN: when defined, a SHALL be (r*90 + 32) >> 6 (round to nearest); when undefined, a SHALL be (r*90) >> 6 (truncate).
REQ-026 Latency, interface and all other behaviour SHALL be identical with and without ARCCOS_ROUND_EN.

Verification
REQ-027 cos_val=255, start pulse -> done 7 cycles later, angle=2 (angle=3 with ARCCOS_ROUND_EN); busy high for 7 cycles.
REQ-028 cos_val=0 -> angle=88 (angle=89 with ARCCOS_ROUND_EN); cos_val=128 -> angle=59.
REQ-029 cos_val=-255 -> angle=178; cos_val=-32768 -> angle=178; cos_val=300 -> angle=2.
REQ-030 cos_val=0 then start re-pulsed with cos_val=255 at cycles +2 and +4 -> single done, angle=88; start in the done cycle with cos_val=-255 -> second done 8 cycles later, angle=178.
REQ-031 rst_n=0 during cycle +3 of a conversion -> busy=0, done=0, angle=0, no done pulse; the next start with cos_val=128 -> angle=59.
